// File: rtl/ysyx_25050147_lsu_axi_pkg.sv
// Shared constants for the LSU AXI4-Lite master: funct3 memory op codes,
// AXI response codes and the controller state encodings.
package ysyx_25050147_lsu_axi_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;
    localparam logic [2:0] OP_WU = 3'b110;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_AR   = 3'd1;
    localparam logic [2:0] ST_R    = 3'd2;
    localparam logic [2:0] ST_AWW  = 3'd3;
    localparam logic [2:0] ST_B    = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

endpackage

// File: rtl/ysyx_25050147_store_align.sv
// Byte-lane alignment for 32-bit stores: shifts store data into its lanes,
// builds the write strobe and flags misaligned or unsupported accesses.
module ysyx_25050147_store_align
    import ysyx_25050147_lsu_axi_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        op,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] wdata_aligned,
    output logic [3:0]        wstrb,
    output logic              misalign
);

    // Lane shift, strobe and legality decode; unsigned ops are loads only.
    always_comb begin
        wdata_aligned = wdata << {addr_lo, 3'b000};
        wstrb         = 4'b0000;
        misalign      = 1'b0;
        case (op)
            OP_B: begin
                wstrb    = 4'b0001 << addr_lo;
                misalign = 1'b0;
            end
            OP_H: begin
                wstrb    = 4'b0011 << addr_lo;
                misalign = addr_lo[0];
            end
            OP_W: begin
                wstrb    = 4'b1111;
                misalign = (addr_lo != 2'b00);
            end
            OP_BU:   misalign = we;
            OP_HU:   misalign = we | addr_lo[0];
            OP_WU:   misalign = we | (addr_lo != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_25050147_lsu_axi.sv
// LSU bus master: runs one core load/store at a time as an AXI4-Lite
// transaction and hands back the raw aligned bus word for extraction.
module ysyx_25050147_lsu_axi
    import ysyx_25050147_lsu_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [2:0]        resp_op,
    output logic [1:0]        resp_addr_lo,
    output logic              resp_we,
    output logic              resp_err,
    output logic              resp_misalign,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    logic [2:0]        state_r;
    logic [2:0]        op_r;
    logic [1:0]        addr_lo_r;
    logic              we_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic              resp_misalign_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              arvalid_r;
    logic              rready_r;
    logic              awvalid_r;
    logic              wvalid_r;
    logic              bready_r;
    logic [ADDR_W-1:0] araddr_r;
    logic [ADDR_W-1:0] awaddr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [3:0]        wstrb_r;
    logic              aw_done_r;
    logic              w_done_r;

    logic [DATA_W-1:0] align_wdata_s;
    logic [3:0]        align_wstrb_s;
    logic              align_misalign_s;
    logic              accept_s;
    logic              aw_fire_s;
    logic              w_fire_s;
    logic              aw_done_s;
    logic              w_done_s;
    logic [ADDR_W-1:0] word_addr_s;

    ysyx_25050147_store_align #(
        .DATA_W (DATA_W)
    ) u_store_align (
        .addr_lo       (req_addr[1:0]),
        .op            (req_op),
        .we            (req_we),
        .wdata         (req_wdata),
        .wdata_aligned (align_wdata_s),
        .wstrb         (align_wstrb_s),
        .misalign      (align_misalign_s)
    );

    assign accept_s    = req_valid & req_ready_r;
    assign word_addr_s = {req_addr[ADDR_W-1:2], 2'b00};
    assign aw_fire_s   = awvalid_r & awready;
    assign w_fire_s    = wvalid_r & wready;
    // A channel counts as done if it finished earlier or is finishing now.
    assign aw_done_s   = aw_done_r | aw_fire_s;
    assign w_done_s    = w_done_r | w_fire_s;

    // Transaction controller; every bus-facing output comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            op_r            <= 3'b000;
            addr_lo_r       <= 2'b00;
            we_r            <= 1'b0;
            req_ready_r     <= 1'b1;
            resp_valid_r    <= 1'b0;
            resp_err_r      <= 1'b0;
            resp_misalign_r <= 1'b0;
            resp_rdata_r    <= {DATA_W{1'b0}};
            arvalid_r       <= 1'b0;
            rready_r        <= 1'b0;
            awvalid_r       <= 1'b0;
            wvalid_r        <= 1'b0;
            bready_r        <= 1'b0;
            araddr_r        <= {ADDR_W{1'b0}};
            awaddr_r        <= {ADDR_W{1'b0}};
            wdata_r         <= {DATA_W{1'b0}};
            wstrb_r         <= 4'b0000;
            aw_done_r       <= 1'b0;
            w_done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_ready_r     <= 1'b0;
                        op_r            <= req_op;
                        addr_lo_r       <= req_addr[1:0];
                        we_r            <= req_we;
                        resp_rdata_r    <= {DATA_W{1'b0}};
                        resp_err_r      <= 1'b0;
                        resp_misalign_r <= 1'b0;
                        if (align_misalign_s) begin
                            state_r         <= ST_RESP;
                            resp_valid_r    <= 1'b1;
                            resp_err_r      <= 1'b1;
                            resp_misalign_r <= 1'b1;
                        end else if (req_we) begin
                            state_r   <= ST_AWW;
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            awaddr_r  <= word_addr_s;
                            wdata_r   <= align_wdata_s;
                            wstrb_r   <= align_wstrb_s;
                            aw_done_r <= 1'b0;
                            w_done_r  <= 1'b0;
                        end else begin
                            state_r   <= ST_AR;
                            arvalid_r <= 1'b1;
                            araddr_r  <= word_addr_s;
                        end
                    end
                end
                ST_AR: begin
                    if (arvalid_r && arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rready_r && rvalid) begin
                        rready_r     <= 1'b0;
                        resp_err_r   <= (rresp != RESP_OKAY);
                        resp_rdata_r <= (rresp == RESP_OKAY) ? rdata : {DATA_W{1'b0}};
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_AWW: begin
                    if (aw_fire_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_fire_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if (aw_done_s && w_done_s) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= ST_B;
                    end
                end
                ST_B: begin
                    if (bready_r && bvalid) begin
                        bready_r     <= 1'b0;
                        resp_err_r   <= (bresp != RESP_OKAY);
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    req_ready_r  <= 1'b1;
                    resp_valid_r <= 1'b0;
                    arvalid_r    <= 1'b0;
                    rready_r     <= 1'b0;
                    awvalid_r    <= 1'b0;
                    wvalid_r     <= 1'b0;
                    bready_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_r;
    assign resp_valid    = resp_valid_r;
    assign resp_rdata    = resp_rdata_r;
    assign resp_op       = op_r;
    assign resp_addr_lo  = addr_lo_r;
    assign resp_we       = we_r;
    assign resp_err      = resp_err_r;
    assign resp_misalign = resp_misalign_r;
    assign araddr        = araddr_r;
    assign arvalid       = arvalid_r;
    assign rready        = rready_r;
    assign awaddr        = awaddr_r;
    assign awvalid       = awvalid_r;
    assign wdata         = wdata_r;
    assign wstrb         = wstrb_r;
    assign wvalid        = wvalid_r;
    assign bready        = bready_r;

endmodule

// File: tb/tb_ysyx_25050147_lsu_axi.sv
// Scoreboard bench for the LSU AXI master: a configurable AXI-Lite slave,
// a response consumer and a monitor checking against queued expectations.
module tb_ysyx_25050147_lsu_axi;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic        we;
        logic        err;
        logic        mis;
        int          lat;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        int          hold;
    } ar_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_hold;
        int          w_hold;
    } w_t;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_op;
    logic [1:0]  resp_addr_lo;
    logic        resp_we, resp_err, resp_misalign;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    ysyx_25050147_lsu_axi dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_op(resp_op), .resp_addr_lo(resp_addr_lo), .resp_we(resp_we),
        .resp_err(resp_err), .resp_misalign(resp_misalign),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    resp_t sb_q[$];
    int    acc_q[$];
    ar_t   ar_q[$];
    w_t    w_q[$];

    // Slave and consumer configuration, set per test.
    int          cfg_ar_stall = 0, cfg_aw_stall = 0, cfg_w_stall = 0, cfg_rr_hold = 0;
    logic [31:0] cfg_rdata = 32'h0;
    logic [1:0]  cfg_rresp = 2'b00, cfg_bresp = 2'b00;
    logic        cfg_r_block = 1'b0;

    int ar_cycles_total = 0, aw_cycles_total = 0, b_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // AXI-Lite slave model with configurable stalls and response codes.
    initial begin : slave
        logic hs_ar, hs_r, hs_aw, hs_w, hs_b;
        logic r_pend, b_pend, aw_got, w_got, ar_moved;
        int ar_hold, aw_hold, w_hold, aw_hold_got, w_hold_got;
        logic [31:0] ar_first, got_awaddr, got_wdata;
        logic [3:0] got_wstrb;
        ar_t ea;
        w_t  ew;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; ar_moved = 1'b0;
        ar_hold = 0; aw_hold = 0; w_hold = 0; aw_hold_got = 0; w_hold_got = 0;
        ar_first = 32'h0; got_awaddr = 32'h0; got_wdata = 32'h0; got_wstrb = 4'h0;
        forever begin
            @(posedge clk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            if (arvalid) begin
                if (ar_hold == 0) ar_first = araddr;
                else if (araddr !== ar_first) ar_moved = 1'b1;
                ar_hold++;
                ar_cycles_total++;
            end
            if (awvalid) begin aw_hold++; aw_cycles_total++; end
            if (wvalid) w_hold++;
            if (hs_ar) begin
                if (r_pend || rvalid) fail_now("ar_while_read_outstanding");
                if (ar_q.size() == 0) fail_now("ar_unexpected");
                else begin
                    ea = ar_q.pop_front();
                    chk("araddr", araddr, ea.addr);
                    chk("araddr_stable", {31'h0, ar_moved}, 32'h0);
                    if (ea.hold >= 0) chk("arvalid_cycles", ar_hold, ea.hold);
                end
                ar_hold = 0; ar_moved = 1'b0; r_pend = 1'b1;
            end
            if (hs_aw) begin
                if (aw_got) fail_now("aw_duplicate");
                aw_got = 1'b1; got_awaddr = awaddr; aw_hold_got = aw_hold; aw_hold = 0;
            end
            if (hs_w) begin
                if (w_got) fail_now("w_duplicate");
                w_got = 1'b1; got_wdata = wdata; got_wstrb = wstrb; w_hold_got = w_hold; w_hold = 0;
            end
            if (aw_got && w_got) begin
                if (w_q.size() == 0) fail_now("write_unexpected");
                else begin
                    ew = w_q.pop_front();
                    chk("awaddr", got_awaddr, ew.addr);
                    chk("wdata", got_wdata, ew.data);
                    chk("wstrb", {28'h0, got_wstrb}, {28'h0, ew.strb});
                    chk("awvalid_cycles", aw_hold_got, ew.aw_hold);
                    chk("wvalid_cycles", w_hold_got, ew.w_hold);
                end
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b1;
            end
            if (hs_b) b_count++;
            #1;
            if (!rst_n) begin
                r_pend = 1'b0; b_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; ar_moved = 1'b0;
                ar_hold = 0; aw_hold = 0; w_hold = 0;
                arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            end else begin
                if (hs_r) rvalid = 1'b0;
                if (hs_b) bvalid = 1'b0;
                if (r_pend && !rvalid && !cfg_r_block) begin
                    rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp; r_pend = 1'b0;
                end
                if (b_pend && !bvalid) begin
                    bvalid = 1'b1; bresp = cfg_bresp; b_pend = 1'b0;
                end
                arready = arvalid && (ar_hold >= cfg_ar_stall);
                awready = awvalid && (aw_hold >= cfg_aw_stall);
                wready  = wvalid && (w_hold >= cfg_w_stall);
            end
        end
    end

    // Response consumer: holds resp_ready low for cfg_rr_hold cycles.
    initial begin : consumer
        int rr_cnt;
        rr_cnt = 0;
        resp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            resp_ready = resp_valid && (rr_cnt >= cfg_rr_hold);
            if (resp_valid) rr_cnt++;
            else rr_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard on each accepted response.
    initial begin : monitor
        logic in_resp, stable, rq_low;
        logic [40:0] snap;
        int lat;
        resp_t e;
        in_resp = 1'b0; stable = 1'b1; rq_low = 1'b1; snap = 41'h0; lat = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_resp = 1'b0;
            end else if (resp_valid) begin
                if (!in_resp) begin
                    in_resp = 1'b1; stable = 1'b1; rq_low = 1'b1;
                    snap = {resp_rdata, resp_op, resp_addr_lo, resp_we, resp_err, resp_misalign};
                    lat = (acc_q.size() > 0) ? (cyc - acc_q.pop_front()) : -1;
                end else if (snap !== {resp_rdata, resp_op, resp_addr_lo, resp_we, resp_err, resp_misalign}) begin
                    stable = 1'b0;
                end
                if (req_ready) rq_low = 1'b0;
                if (resp_ready) begin
                    in_resp = 1'b0;
                    if (sb_q.size() == 0) fail_now("resp_unexpected");
                    else begin
                        e = sb_q.pop_front();
                        chk("resp_rdata", resp_rdata, e.rdata);
                        chk("resp_op", {29'h0, resp_op}, {29'h0, e.op});
                        chk("resp_addr_lo", {30'h0, resp_addr_lo}, {30'h0, e.lo});
                        chk("resp_we", {31'h0, resp_we}, {31'h0, e.we});
                        chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                        chk("resp_misalign", {31'h0, resp_misalign}, {31'h0, e.mis});
                        chk("resp_stable", {31'h0, stable}, 32'h1);
                        chk("req_ready_low_in_resp", {31'h0, rq_low}, 32'h1);
                        if (e.lat >= 0) chk("resp_latency", lat, e.lat);
                    end
                end
            end
        end
    end

    task automatic exp_ar(input logic [31:0] addr, input int hold);
        ar_t a;
        a.addr = addr; a.hold = hold;
        ar_q.push_back(a);
    endtask

    task automatic exp_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input int awh, input int wh);
        w_t w;
        w.addr = addr; w.data = data; w.strb = strb; w.aw_hold = awh; w.w_hold = wh;
        w_q.push_back(w);
    endtask

    // Presents one request (called at #1 after a rising edge) and queues its response.
    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] e_rdata,
                         input logic e_err, input logic e_mis, input int e_lat);
        resp_t e;
        logic accepted;
        e.rdata = e_rdata; e.op = op; e.lo = addr[1:0]; e.we = we;
        e.err = e_err; e.mis = e_mis; e.lat = e_lat;
        sb_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wd;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(posedge clk);
            if (req_ready) begin
                accepted = 1'b1;
                acc_q.push_back(cyc);
            end
        end
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        if (!accepted) fail_now("req_accept_timeout");
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb_q.size() != 0) begin
            fail_now("response_timeout");
            sb_q.delete();
            acc_q.delete();
        end
        cfg_ar_stall = 0; cfg_aw_stall = 0; cfg_w_stall = 0; cfg_rr_hold = 0;
        cfg_rresp = 2'b00; cfg_bresp = 2'b00; cfg_rdata = 32'h0;
    endtask

    initial begin : stim
        int ar_before, aw_before;
        logic got;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_arvalid", {31'h0, arvalid}, 32'h0);
        chk("rst_awvalid_wvalid", {30'h0, awvalid, wvalid}, 32'h0);
        chk("rst_rready_bready", {30'h0, rready, bready}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // lw with 2-cycle arready stall
        cfg_ar_stall = 2; cfg_rdata = 32'hDEADBEEF;
        exp_ar(32'h8000_0004, 3);
        issue(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 5);
        wait_idle();

        // sb to the top byte lane
        exp_w(32'h8000_0000, 32'hA500_0000, 4'b1000, 1, 1);
        issue(1'b1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1'b0, 1'b0, 3);
        wait_idle();

        // sh with awready arriving 3 cycles before wready
        cfg_w_stall = 3;
        exp_w(32'h8000_0000, 32'hBEEF_0000, 4'b1100, 1, 4);
        issue(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 6);
        wait_idle();

        // misaligned lh: no bus traffic
        ar_before = ar_cycles_total; aw_before = aw_cycles_total;
        issue(1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        wait_idle();
        chk("lh_mis_no_arvalid", ar_cycles_total, ar_before);
        chk("lh_mis_no_awvalid", aw_cycles_total, aw_before);

        // lw with SLVERR and a slow consumer
        cfg_rresp = 2'b10; cfg_rdata = 32'hCAFE_F00D; cfg_rr_hold = 5;
        exp_ar(32'h8000_0008, 1);
        issue(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h0, 1'b1, 1'b0, 3);
        wait_idle();

        // reset while waiting in R
        cfg_r_block = 1'b1;
        exp_ar(32'h8000_0010, 1);
        issue(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h0, 1'b0, 1'b0, -1);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rready) got = 1'b1;
        end
        chk("reset_test_reached_r", {31'h0, got}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_rready", {31'h0, rready}, 32'h0);
        chk("async_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        sb_q.delete();
        acc_q.delete();
        cfg_r_block = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        cfg_rdata = 32'h0123_4567;
        exp_ar(32'h8000_0020, 1);
        issue(1'b0, 3'b010, 32'h8000_0020, 32'h0, 32'h0123_4567, 1'b0, 1'b0, 3);
        wait_idle();

        // lbu: raw word plus byte offset returned
        cfg_rdata = 32'h1122_3344;
        exp_ar(32'h8000_0000, 1);
        issue(1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h1122_3344, 1'b0, 1'b0, 3);
        wait_idle();

        // sw with bus error response
        cfg_bresp = 2'b10;
        exp_w(32'h8000_000C, 32'h1234_5678, 4'b1111, 1, 1);
        issue(1'b1, 3'b010, 32'h8000_000C, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 3);
        wait_idle();

        // unsupported store op 011
        aw_before = aw_cycles_total;
        issue(1'b1, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1);
        wait_idle();
        chk("bad_store_no_awvalid", aw_cycles_total, aw_before);

        // misaligned lw
        ar_before = ar_cycles_total;
        issue(1'b0, 3'b010, 32'h8000_0006, 32'h0, 32'h0, 1'b1, 1'b1, 1);
        wait_idle();
        chk("lw_mis_no_arvalid", ar_cycles_total, ar_before);

        repeat (3) @(posedge clk);
        chk("ar_queue_drained", ar_q.size(), 0);
        chk("w_queue_drained", w_q.size(), 0);
        chk("b_handshakes", b_count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
